// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller and the ALU decoder:
// controller states, instruction class codes and special funct values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [1:0] CLS_R   = 2'b00;
    localparam logic [1:0] CLS_I   = 2'b01;
    localparam logic [1:0] CLS_B   = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [3:0] F_LD   = 4'b1000;
    localparam logic [3:0] F_ST   = 4'b1001;
    localparam logic [3:0] F_HALT = 4'b1111;

    function automatic logic is_run(input state_t s);
        return !(s == S_IDLE || s == S_HALT || s == S_ERR);
    endfunction

endpackage

// File: rtl/ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (priority) and enable.
// Ports: clk, rst_n, clr, en in; cnt out (W bits, sticks at all ones).
module ctrl_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: fetch/decode/exec/mem/wb sequencing,
// instruction register, imem/dmem req/ack with timeout, cycle counter.
// Ports: clk, rst_n, start, instr, imem/dmem handshakes, zero in;
// ALU fields, pc/rf/mem strobes, busy/done/err and cycle_cnt out.
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [8:0]       instr,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             dmem_we,
    input  logic             zero,
    output logic [1:0]       alu_op,
    output logic [3:0]       funct,
    output logic [2:0]       operand,
    output logic             pc_en,
    output logic             pc_src,
    output logic             rf_we,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt
);

    // The wait count only needs to reach MEM_TO-1: the cycle holding
    // that value is the last request cycle in which an ack is accepted.
    localparam int WAIT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

    state_t            st, nxt;
    logic [8:0]        ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cls;
    logic [3:0]        fn;
    logic              is_ld, is_st, to, go;
    logic              wclr, wen;

    assign cls   = ir[8:7];
    assign fn    = ir[6:3];
    assign is_ld = (cls == CLS_I) && (fn == F_LD);
    assign is_st = (cls == CLS_I) && (fn == F_ST);
    assign to    = (wait_cnt == WAIT_LAST);
    assign go    = start && !is_run(st);

    assign alu_op  = ir[8:7];
    assign funct   = ir[6:3];
    assign operand = ir[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= S_IDLE;
        else
            st <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= '0;
        else if (st == S_FETCH && imem_ack)
            ir <= instr;
    end

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE, S_HALT, S_ERR:
                if (start) nxt = S_FETCH;
            S_FETCH:
                if (imem_ack) nxt = S_DECODE;
                else if (to)  nxt = S_ERR;
            S_DECODE:
                if (cls == CLS_SYS)
                    nxt = (fn == F_HALT) ? S_HALT : S_FETCH;
                else
                    nxt = S_EXEC;
            S_EXEC:
                unique case (1'b1)
                    (is_ld || is_st):                 nxt = S_MEM;
                    (cls == CLS_B || cls == CLS_SYS): nxt = S_FETCH;
                    default:                          nxt = S_WB;
                endcase
            S_MEM:
                if (dmem_ack) nxt = is_ld ? S_WB : S_FETCH;
                else if (to)  nxt = S_ERR;
            S_WB:
                nxt = S_FETCH;
            default:
                nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        rf_we      = 1'b0;
        mem_to_reg = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = is_run(st);
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                pc_en    = imem_ack;
            end
            S_EXEC: begin
                pc_src = (cls == CLS_B);
                pc_en  = (cls == CLS_B) && (fn[3] || zero);
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
            end
            S_WB: begin
                rf_we      = 1'b1;
                mem_to_reg = is_ld;
            end
            S_HALT: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    // Restart the wait count on every entry into a request state.
    assign wclr = (nxt == S_FETCH && st != S_FETCH)
               || (nxt == S_MEM && st != S_MEM);
    assign wen  = (st == S_FETCH && !imem_ack)
               || (st == S_MEM && !dmem_ack);

    ctrl_sat_cnt #(.W(WAIT_W)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wclr),
        .en    (wen),
        .cnt   (wait_cnt)
    );

    ctrl_sat_cnt #(.W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .en    (busy),
        .cnt   (cycle_cnt)
    );

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the 9-bit processor core. Sequences each instruction through fetch, decode, execute, memory and write-back. It owns the instruction register and drives the 2-bit ALU class and 4-bit funct field into the existing ALU decoder. It also handles the instruction and data memory req/ack handshakes, raises done on halt, and keeps a saturating cycle count for program benchmarking.

## Interface
Parameters:
- CNT_W, 16: width of cycle counter.
- MEM_TO, 15: max wait cycles for any ack before error; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins execution from IDLE, HALT or ERR.
- instr  in  9  instruction from imem, valid when imem_ack=1.
- imem_req / imem_ack  out / in  1 / 1  fetch handshake.
- dmem_req / dmem_ack  out / in  1 / 1  data access handshake.
- dmem_we  out  1  store qualifier, valid with dmem_req.
- zero  in  1  ALU zero flag, sampled in EXEC.
- alu_op  out  2  ALU class to decoder; equals ir[8:7].
- funct  out  4  funct to decoder; equals ir[6:3].
- operand  out  3  ir[2:0] to register file or immediate logic.
- pc_en  out  1  one-cycle PC update strobe.
- pc_src  out  1  0 = PC+1, 1 = branch target; valid with pc_en.
- rf_we  out  1  register file write enable.
- mem_to_reg  out  1  write-back source is dmem.
- busy, done, err  out  1 each  status.
- cycle_cnt  out  CNT_W  executed cycles since last start.

## Operation
- IR fields: class = ir[8:7], funct = ir[6:3], operand = ir[2:0].
- Class 00, R-type ALU: EXEC→WB.
- Class 01, immediate:
  - funct 1000 is load: EXEC→MEM→WB with mem_to_reg=1.
  - funct 1001 is store: EXEC→MEM with dmem_we=1.
  - Any other funct is ALU-imm: EXEC→WB.
- Class 10, branch:
  - funct[3]=0 is EQ. In EXEC, branch taken iff zero=1.
  - funct[3]=1 is unconditional jump.
  - EXEC returns to FETCH. A taken branch pulses pc_en=1 with pc_src=1.
- Class 11: funct 1111 is halt (DECODE→HALT). Any other funct is a NOP (DECODE→FETCH).
- States and transitions:
  - IDLE: start→FETCH.
  - FETCH: imem_req=1. On imem_ack, load IR and pulse pc_en with pc_src=0, then go to DECODE.
  - DECODE: class 11 handled here; all others go to EXEC.
  - EXEC, MEM, WB as listed per class.
  - HALT: done=1. start→FETCH.
  - ERR: err=1. start→FETCH.
- Request lines:
  - imem_req holds high in FETCH until ack.
  - dmem_req holds high in MEM until ack.
  - Neither request may drop before its ack.
  - An ack that arrives outside the matching state is ignored.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle without ack.
  - Reaching MEM_TO without ack → ERR. The request drops in ERR.
- rf_we=1 only in WB.
- busy=1 in every state except IDLE, HALT and ERR.
- start is ignored while busy.
- start accepted → cycle_cnt cleared to 0 and IR preserved.
- cycle_cnt:
  - Increments every cycle busy=1.
  - Saturates at all ones; no wrap.
  - Holds its value in HALT and ERR.

## Timing
- Reset values: state IDLE, IR 0, wait counter 0, cycle_cnt 0. Every output is 0 (alu_op and funct 0 because IR is 0).
- Reset is asynchronous at any state, including mid-handshake. Requests drop immediately; no partial write-back.
- State, IR and counters are registered.
- All control outputs are combinational from state and IR, with no input-to-output path except:
  - pc_en in FETCH, which is gated by imem_ack;
  - pc_en in EXEC, which is gated by zero.
- Latency with zero-wait acks (ack in the first request cycle):
  - R, ALU-imm: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
  - Halt: done rises 2 cycles after FETCH entry.
  - Each ack wait cycle adds 1.
- start and a completion event in the same cycle: start is ignored unless the state is already IDLE, HALT or ERR.
- Timeout at exactly MEM_TO: with MEM_TO=15, an ack in the 15th request cycle is accepted. No ack in that cycle → ERR on the next edge.

## Structure
- Package ctrl_pkg:
  - state enum;
  - class codes CLS_R, CLS_I, CLS_B, CLS_SYS;
  - funct constants F_LD=1000, F_ST=1001, F_HALT=1111.
- The ALU decoder shares ctrl_pkg class codes.
- One sub-module, ctrl_sat_cnt: a parameterised saturating counter with clear and enable. It is used for both cycle_cnt and the wait counter.

## Test plan
- Reset then start, instr 0x001 (R add), ack in the same cycle: pc_en in cycle 1; rf_we in cycle 4; alu_op=00, funct=0000; cycle_cnt=4 at next FETCH.
- Load 0x0C0, dmem_ack delayed 3 cycles: dmem_req held 4 cycles; mem_to_reg=1 and rf_we=1 in WB; total 8 cycles.
- Branch EQ 0x10A: with zero=1 → pc_en=1 and pc_src=1 in EXEC. With zero=0 → no EXEC pc_en. Jump 0x140 always taken.
- Halt 0x1F8 → done=1 and busy=0 in the cycle after DECODE; cycle_cnt frozen. A later start clears done and cycle_cnt.
- imem_ack never asserted, MEM_TO=15: after 15 request cycles → err=1 and imem_req=0. start recovers to FETCH.
- rst_n low during MEM with dmem_req=1: dmem_req drops asynchronously; all outputs 0; state IDLE.
